// File: rtl/csr_unit_if.sv
// Bundle of the CSR unit's request, CSR-file, register-file and status signals.
// The master side is decode plus the CSR file; the slave side is csr_unit.
interface csr_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_data;
  logic [4:0]  rd_idx;
  logic        flush;

  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata_i;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;

  logic        rd_we;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;

  logic        done;
  logic        illegal;

  modport master (
    output req_valid, funct3, csr_addr, rs1_idx, rs1_data, rd_idx, flush,
           csr_rdata_i,
    input  req_ready, csr_raddr, csr_we, csr_waddr, csr_wdata,
           rd_we, rd_waddr, rd_wdata, done, illegal
  );

  modport slave (
    input  req_valid, funct3, csr_addr, rs1_idx, rs1_data, rd_idx, flush,
           csr_rdata_i,
    output req_ready, csr_raddr, csr_we, csr_waddr, csr_wdata,
           rd_we, rd_waddr, rd_wdata, done, illegal
  );
endinterface

// File: rtl/csr_unit.sv
// Zicsr instruction executor: IDLE accepts, READ samples the CSR file and
// computes the new value, WRITE commits both register-file ports and pulses done.
module csr_unit (
  input  logic       clk,
  input  logic       rst,
  csr_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [2:0]  f3_q;
  logic [11:0] addr_q;
  logic [4:0]  rs1_q;
  logic [31:0] rs1_data_q;
  logic [4:0]  rd_q;
  logic [31:0] old_q;
  logic [31:0] new_q;

  logic        accept;
  logic [31:0] src;
  logic [31:0] new_val;
  logic        wr_intent;
  logic        bad_op;
  logic        is_illegal;

  assign accept = bus.req_valid && (state == IDLE) && !bus.flush;

  // Immediate forms carry the zero-extended zimm in the rs1 field.
  assign src = f3_q[2] ? {27'b0, rs1_q} : rs1_data_q;

  always_comb begin
    new_val = '0;
    unique case (f3_q[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = bus.csr_rdata_i | src;
      2'b11:   new_val = bus.csr_rdata_i & ~src;
      default: new_val = '0;
    endcase
  end

  // Set/clear forms with rs1/zimm == 0 are pure reads and must not trip the
  // read-only address check.
  assign wr_intent  = (f3_q[1:0] == 2'b01) || (rs1_q != 5'd0);
  assign bad_op     = (f3_q[1:0] == 2'b00);
  assign is_illegal = bad_op || ((addr_q[11:10] == 2'b11) && wr_intent);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f3_q       <= '0;
      addr_q     <= '0;
      rs1_q      <= '0;
      rs1_data_q <= '0;
      rd_q       <= '0;
      old_q      <= '0;
      new_q      <= '0;
    end else begin
      if (accept) begin
        f3_q       <= bus.funct3;
        addr_q     <= bus.csr_addr;
        rs1_q      <= bus.rs1_idx;
        rs1_data_q <= bus.rs1_data;
        rd_q       <= bus.rd_idx;
      end
      if (state == READ) begin
        old_q <= bus.csr_rdata_i;
        new_q <= new_val;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.csr_we    = 1'b0;
    bus.rd_we     = 1'b0;
    bus.done      = 1'b0;
    bus.illegal   = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) state_nxt = READ;
      end
      READ: begin
        state_nxt = bus.flush ? IDLE : WRITE;
      end
      WRITE: begin
        bus.done    = 1'b1;
        bus.illegal = is_illegal;
        bus.csr_we  = !is_illegal && wr_intent;
        bus.rd_we   = !is_illegal && (rd_q != 5'd0);
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.csr_raddr = addr_q;
  assign bus.csr_waddr = addr_q;
  assign bus.csr_wdata = new_q;
  assign bus.rd_waddr  = rd_q;
  assign bus.rd_wdata  = old_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed and randomized checks of csr_unit against a transaction-level
// CSR model; the bench also plays the CSR file behind the unit.
module tb_csr_unit;

  logic clk = 1'b0;
  logic rst;
  logic env_init;

  always #5 clk = ~clk;

  csr_unit_if bus ();

  csr_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned fails  = 0;

  logic [31:0] ref_mem [0:4095];
  logic [31:0] env_mem [0:4095];
  logic [4095:0] env_wr;
  logic [11:0] touched [$];

  function automatic logic [31:0] init_val(input logic [11:0] a);
    case (a)
      12'h340: return 32'h0000AAAA;
      12'hF11: return 32'h013109F5;
      12'h344: return 32'hFFFFFFFF;
      default: return {a, 20'h0} ^ (32'(a) * 32'h9E3779B1);
    endcase
  endfunction

  function automatic logic [31:0] env_val(input logic [11:0] a);
    return env_wr[a] ? env_mem[a] : init_val(a);
  endfunction

  // CSR file seen by the unit: combinational read, write on the clock edge.
  assign bus.csr_rdata_i = env_val(bus.csr_raddr);

  always @(posedge clk) begin
    if (env_init) begin
      env_wr <= '0;
    end else if (bus.csr_we) begin
      env_mem[bus.csr_waddr] <= bus.csr_wdata;
      env_wr[bus.csr_waddr]  <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                           input logic [31:0] d, input logic [4:0] rd);
    bus.req_valid = 1'b1;
    bus.funct3    = f3;
    bus.csr_addr  = a;
    bus.rs1_idx   = r1;
    bus.rs1_data  = d;
    bus.rd_idx    = rd;
  endtask

  task automatic scramble();
    bus.funct3   = 3'($urandom);
    bus.csr_addr = 12'($urandom);
    bus.rs1_idx  = 5'($urandom);
    bus.rs1_data = $urandom;
    bus.rd_idx   = 5'($urandom);
  endtask

  // fmode: 0 plain, 1 flush during READ, 2 flush during WRITE
  task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                        input logic [31:0] d, input logic [4:0] rd, input int fmode);
    logic [31:0] old_v, src, nv;
    logic        wr, ill;
    old_v = ref_mem[a];
    src   = f3[2] ? {27'b0, r1} : d;
    case (f3[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old_v | src;
      2'b11:   nv = old_v & ~src;
      default: nv = old_v;
    endcase
    wr  = (f3[1:0] == 2'b01) || (r1 != 5'd0);
    ill = (f3[1:0] == 2'b00) || ((a[11:10] == 2'b11) && wr);
    touched.push_back(a);

    @(negedge clk);
    chk("ready_idle", 32'(bus.req_ready), 32'd1);
    drive_req(f3, a, r1, d, rd);
    @(posedge clk); #1;
    chk("ready_read", 32'(bus.req_ready), 32'd0);
    chk("raddr_read", 32'(bus.csr_raddr), 32'(a));
    chk("pulses_read", 32'({bus.done, bus.illegal, bus.csr_we, bus.rd_we}), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    scramble();
    if (fmode == 1) bus.flush = 1'b1;
    @(posedge clk); #1;
    if (fmode == 1) begin
      bus.flush = 1'b0;
      chk("flush_read_pulses", 32'({bus.done, bus.illegal, bus.csr_we, bus.rd_we}), 32'd0);
      chk("flush_read_ready", 32'(bus.req_ready), 32'd1);
      return;
    end
    if (fmode == 2) begin
      bus.flush = 1'b1;
      #1;
    end
    chk("done", 32'(bus.done), 32'd1);
    chk("illegal", 32'(bus.illegal), 32'(ill));
    chk("csr_we", 32'(bus.csr_we), 32'(wr && !ill));
    if (wr && !ill) begin
      chk("csr_waddr", 32'(bus.csr_waddr), 32'(a));
      chk("csr_wdata", bus.csr_wdata, nv);
      ref_mem[a] = nv;
    end
    chk("rd_we", 32'(bus.rd_we), 32'(!ill && (rd != 5'd0)));
    if (!ill && (rd != 5'd0)) begin
      chk("rd_waddr", 32'(bus.rd_waddr), 32'(rd));
      chk("rd_wdata", bus.rd_wdata, old_v);
    end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("ready_after", 32'(bus.req_ready), 32'd1);
    chk("pulses_after", 32'({bus.done, bus.illegal, bus.csr_we, bus.rd_we}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  f3;
    logic [11:0] a;
    logic [4:0]  r1, rd;
    int          fm;

    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    scramble();
    env_init = 1'b1;
    rst      = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_pulses", 32'({bus.done, bus.illegal, bus.csr_we, bus.rd_we}), 32'd0);
    chk("rst_raddr", 32'(bus.csr_raddr), 32'd0);
    chk("rst_wdata", bus.csr_wdata, 32'd0);
    chk("rst_rd_wdata", bus.rd_wdata, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    env_init = 1'b0;
    rst      = 1'b1;

    // CSRRW rd=5 on mscratch
    run_op(3'b001, 12'h340, 5'd1, 32'h00001234, 5'd5, 0);
    // CSRRSI zimm=0 on mvendorid reads only; CSRRWI there is illegal
    run_op(3'b110, 12'hF11, 5'd0, 32'hDEADBEEF, 5'd3, 0);
    run_op(3'b101, 12'hF11, 5'd4, 32'h0, 5'd3, 0);
    // CSRRC clearing low nibble, rd=x0
    run_op(3'b011, 12'h344, 5'd6, 32'h0000000F, 5'd0, 0);
    // CSRRCI / CSRRSI zimm zero-extension
    run_op(3'b111, 12'h344, 5'd31, 32'hFFFFFFFF, 5'd7, 0);
    run_op(3'b110, 12'h340, 5'd16, 32'hFFFFFFFF, 5'd8, 0);
    // flush in READ, then in WRITE
    run_op(3'b001, 12'h341, 5'd2, 32'h55AA55AA, 5'd9, 1);
    run_op(3'b001, 12'h341, 5'd2, 32'h12345678, 5'd9, 2);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    drive_req(3'b001, 12'h342, 5'd1, 32'h1, 5'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_idle_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    @(posedge clk); #1;
    chk("flush_idle_pulses", 32'({bus.done, bus.csr_we, bus.rd_we}), 32'd0);

    // Back-to-back with req_valid held high
    touched.push_back(12'h305);
    @(negedge clk);
    drive_req(3'b001, 12'h305, 5'd7, 32'hCAFEF00D, 5'd9);
    @(posedge clk); #1;
    chk("b2b_ready0", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    drive_req(3'b010, 12'h305, 5'd2, 32'h00000F00, 5'd10);
    @(posedge clk); #1;
    chk("b2b_ready1", 32'(bus.req_ready), 32'd0);
    chk("b2b_a_wdata", bus.csr_wdata, 32'hCAFEF00D);
    chk("b2b_a_rdata", bus.rd_wdata, ref_mem[12'h305]);
    @(posedge clk); #1;
    chk("b2b_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("b2b_ready_acc", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_b_rd_wdata", bus.rd_wdata, 32'hCAFEF00D);
    chk("b2b_b_wdata", bus.csr_wdata, 32'hCAFEFF0D);
    ref_mem[12'h305] = 32'hCAFEFF0D;
    @(posedge clk); #1;

    // Reset during WRITE abandons the access
    touched.push_back(12'h343);
    @(negedge clk);
    drive_req(3'b001, 12'h343, 5'd3, 32'h0BADF00D, 5'd6);
    @(posedge clk); #1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstw_done_before", 32'(bus.done), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstw_pulses", 32'({bus.done, bus.illegal, bus.csr_we, bus.rd_we}), 32'd0);
    chk("rstw_ready", 32'(bus.req_ready), 32'd1);
    chk("rstw_raddr", 32'(bus.csr_raddr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(3'b000, 12'h300, 5'd1, 32'h1, 5'd1, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom);
      a  = 12'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      fm = $urandom_range(0, 7);
      fm = (fm == 0) ? 1 : ((fm == 1) ? 2 : 0);
      run_op(f3, a, r1, $urandom, rd, fm);
    end

    // CSR file contents must match the model at every address touched
    foreach (touched[k]) chk("csr_file", env_val(touched[k]), ref_mem[touched[k]]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
